cp0_param: RTL and testbench

CP0_PARAM -- requirements
Module: cp0_param

---
 rtl/cp0_param.sv | 107 ++++++++++
 tb/tb_cp0_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_param.sv
// cp0_param: MIPS-style CP0 with Count/Compare timer, interrupt synchronisers,
// Status/Cause/EPC/BadVAddr registers and exception/ERET sequencing.
module cp0_param #(
   parameter int          N_HWINT     = 6,
   parameter int          COUNT_DIV   = 2,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] EXC_BASE    = 32'hBFC00380
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [7:0]         addr,
   input  logic [31:0]        wdata,
   input  logic               exc_valid,
   input  logic [4:0]         exc_code,
   input  logic               exc_bd,
   input  logic [31:0]        exc_pc,
   input  logic [31:0]        exc_badvaddr,
   input  logic               eret,
   input  logic [N_HWINT-1:0] ext_int,
   output logic [31:0]        rdata,
   output logic [31:0]        epc_out,
   output logic [31:0]        exc_vector,
   output logic               int_req
);
   localparam logic [4:0] PMAX = 5'(COUNT_DIV - 1);
   logic [31:0] count, compare, epc, badvaddr, status, cause;
   logic [4:0] pre, code;
   logic [7:0] im, ip;
   logic [5:0] hw;
   logic [1:0] ip_sw;
   logic exl, ie, ti, bd;
   logic [N_HWINT-1:0] ext_s;
   logic wr_count, wr_cmp, wr_status, wr_cause, wr_epc;
   assign wr_count  = wr_en && addr == 8'h48;
   assign wr_cmp    = wr_en && addr == 8'h58;
   assign wr_status = wr_en && addr == 8'h60;
   assign wr_cause  = wr_en && addr == 8'h68;
   assign wr_epc    = wr_en && addr == 8'h70;
   generate
      if (SYNC_STAGES == 0) begin : g_direct
         assign ext_s = ext_int;
      end else begin : g_sync
         logic [N_HWINT-1:0] sr [SYNC_STAGES];
         always_ff @(posedge clk) begin
            if (!rst) begin
               for (int k = 0; k < SYNC_STAGES; k++) sr[k] <= '0;
            end else begin
               sr[0] <= ext_int;
               for (int k = 1; k < SYNC_STAGES; k++) sr[k] <= sr[k-1];
            end
         end
         assign ext_s = sr[SYNC_STAGES-1];
      end
   endgenerate
   always_comb begin
      hw = '0;
      for (int i = 0; i < N_HWINT; i++) hw[i] = ext_s[i];
   end
   // IP7 doubles as the timer interrupt line
   assign ip         = {hw[5] | ti, hw[4:0], ip_sw};
   assign status     = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
   assign cause      = {bd, ti, 14'b0, ip, 1'b0, code, 2'b0};
   assign int_req    = |(ip & im) & ie & ~exl;
   assign epc_out    = epc;
   assign exc_vector = status[22] ? EXC_BASE : 32'h80000180;
   assign rdata = addr == 8'h40 ? badvaddr :
                  addr == 8'h48 ? count    :
                  addr == 8'h58 ? compare  :
                  addr == 8'h60 ? status   :
                  addr == 8'h68 ? cause    :
                  addr == 8'h70 ? epc      : 32'h0;
   always_ff @(posedge clk) begin
      if (!rst) begin
         count    <= '0;
         compare  <= 32'hFFFFFFFF;
         pre      <= '0;
         epc      <= '0;
         badvaddr <= '0;
         im       <= '0;
         ip_sw    <= '0;
         code     <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         ti       <= 1'b0;
         bd       <= 1'b0;
      end else begin
         pre   <= (wr_count || pre == PMAX) ? 5'd0 : pre + 5'd1;
         count <= wr_count ? wdata : (pre == PMAX) ? count + 32'd1 : count;
         if (wr_cmp) compare <= wdata;
         ti    <= wr_cmp ? 1'b0 : ti | (count == compare);
         if (wr_cause) ip_sw <= wdata[9:8];
         if (wr_status) begin
            im <= wdata[15:8];
            ie <= wdata[0];
         end
         exl <= exc_valid ? 1'b1 : eret ? 1'b0 : wr_status ? wdata[1] : exl;
         if (exc_valid) code <= exc_code;
         // a nested exception keeps the original return address
         if (exc_valid && !exl) begin
            epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
            bd  <= exc_bd;
         end else if (!exc_valid && wr_epc) epc <= wdata;
         if (exc_valid && (exc_code == 5'd4 || exc_code == 5'd5)) badvaddr <= exc_badvaddr;
      end
   end
endmodule

// File: tb/tb_cp0_param.sv
// tb_cp0_param: checks two cp0_param builds (default, and div1/4 lines/no sync)
// against a cycle-count based reference model.
module tb_cp0_param;
   logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, exc_valid = 1'b0, exc_bd = 1'b0, eret = 1'b0;
   logic [7:0] addr = 8'h0;
   logic [31:0] wdata = '0, exc_pc = '0, exc_badvaddr = '0;
   logic [4:0] exc_code = '0;
   logic [5:0] ext_int = '0;
   logic [31:0] rdata0, epc0, vec0, rdata1, epc1, vec1;
   logic irq0, irq1;
   int errors = 0, checks = 0;
   logic [31:0] cbase, cmp, epc, bva;
   int cyc;
   logic ti0, ti1, exl, ie, bdm;
   logic [7:0] im;
   logic [1:0] ip10;
   logic [4:0] code;
   logic [5:0] last0, last1;
   always #5 clk = ~clk;
   cp0_param u0 (.clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_bd(exc_bd), .exc_pc(exc_pc),
      .exc_badvaddr(exc_badvaddr), .eret(eret), .ext_int(ext_int), .rdata(rdata0),
      .epc_out(epc0), .exc_vector(vec0), .int_req(irq0));
   cp0_param #(.N_HWINT(4), .COUNT_DIV(1), .SYNC_STAGES(0)) u1 (.clk(clk), .rst(rst),
      .wr_en(wr_en), .addr(addr), .wdata(wdata), .exc_valid(exc_valid), .exc_code(exc_code),
      .exc_bd(exc_bd), .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr), .eret(eret),
      .ext_int(ext_int[3:0]), .rdata(rdata1), .epc_out(epc1), .exc_vector(vec1), .int_req(irq1));
   function automatic logic [31:0] mcount(int div);
      return cbase + 32'(cyc / div);
   endfunction
   function automatic logic [7:0] mip(int u);
      return u == 0 ? {last1[5] | ti0, last1[4:0], ip10} : {ti1, 1'b0, ext_int[3:0], ip10};
   endfunction
   function automatic logic mirq(int u);
      return |(mip(u) & im) & ie & ~exl;
   endfunction
   function automatic logic [31:0] mrd(int u, logic [7:0] a);
      case (a)
         8'h40: return bva;
         8'h48: return mcount(u == 0 ? 2 : 1);
         8'h58: return cmp;
         8'h60: return {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
         8'h68: return {bdm, u == 0 ? ti0 : ti1, 14'b0, mip(u), 1'b0, code, 2'b0};
         8'h70: return epc;
         default: return 32'h0;
      endcase
   endfunction
   task automatic tick();
      logic [31:0] c0, c1;
      logic wc;
      c0 = mcount(2);
      c1 = mcount(1);
      wc = wr_en && addr == 8'h58;
      @(posedge clk);
      if (!rst) begin
         cbase = 0; cyc = 0; cmp = 32'hFFFFFFFF; epc = 0; bva = 0; ti0 = 0; ti1 = 0;
         exl = 0; ie = 0; bdm = 0; im = 0; ip10 = 0; code = 0; last0 = 0; last1 = 0;
      end else begin
         ti0 = wc ? 1'b0 : ti0 | (c0 == cmp);
         ti1 = wc ? 1'b0 : ti1 | (c1 == cmp);
         if (wc) cmp = wdata;
         if (wr_en && addr == 8'h48) begin cbase = wdata; cyc = 0; end else cyc++;
         if (exc_valid) begin
            if (!exl) begin epc = exc_bd ? exc_pc - 32'd4 : exc_pc; bdm = exc_bd; end
            exl = 1;
            code = exc_code;
            if (exc_code == 5'd4 || exc_code == 5'd5) bva = exc_badvaddr;
         end else if (eret) exl = 0;
         if (wr_en && addr == 8'h60) begin
            im = wdata[15:8];
            ie = wdata[0];
            if (!exc_valid && !eret) exl = wdata[1];
         end
         if (wr_en && addr == 8'h68) ip10 = wdata[9:8];
         if (wr_en && addr == 8'h70 && !exc_valid) epc = wdata;
         last1 = last0;
         last0 = ext_int;
      end
      #1 wr_en = 0; exc_valid = 0; eret = 0;
   endtask
   task automatic wr(logic [7:0] a, logic [31:0] d);
      wr_en = 1; addr = a; wdata = d;
      tick();
   endtask
   task automatic test_reset();
      logic [7:0] a [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h50};
      logic [31:0] e [7] = '{0, 0, 32'hFFFFFFFF, 32'h00400000, 0, 0, 0};
      rst = 0;
      tick(); tick();
      for (int i = 0; i < 7; i++) begin
         addr = a[i]; #1;
         checks++; if (rdata0 !== e[i]) begin errors++; $display("FAIL reset_u0 addr=%h got=%h exp=%h", a[i], rdata0, e[i]); end
         checks++; if (rdata1 !== e[i]) begin errors++; $display("FAIL reset_u1 addr=%h got=%h exp=%h", a[i], rdata1, e[i]); end
      end
      checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b%b exp=00", irq0, irq1); end
      checks++; if (vec0 !== 32'hBFC00380) begin errors++; $display("FAIL reset_vec got=%h exp=bfc00380", vec0); end
      checks++; if (epc0 !== 32'h0) begin errors++; $display("FAIL reset_epc got=%h exp=0", epc0); end
      rst = 1;
   endtask
   task automatic test_count();
      repeat (10) tick();
      addr = 8'h48; #1;
      checks++; if (rdata0 !== 32'd5) begin errors++; $display("FAIL count_div2 got=%0d exp=5", rdata0); end
      checks++; if (rdata1 !== 32'd10) begin errors++; $display("FAIL count_div1 got=%0d exp=10", rdata1); end
      wr(8'h48, 32'hFFFFFFFF);
      tick(); #1;
      checks++; if (rdata0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL count_hold got=%h exp=ffffffff", rdata0); end
      tick(); #1;
      checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL count_wrap got=%h exp=0", rdata0); end
      checks++; if (rdata1 !== mrd(1, 8'h48)) begin errors++; $display("FAIL count_u1 got=%h exp=%h", rdata1, mrd(1, 8'h48)); end
   endtask
   task automatic test_timer();
      wr(8'h58, 32'd8);
      wr(8'h48, 32'd6);
      wr(8'h60, 32'h00008001);
      tick(); addr = 8'h68; #1;
      checks++; if (rdata1[30] !== 1'b0) begin errors++; $display("FAIL ti_early got=%b exp=0", rdata1[30]); end
      tick(); addr = 8'h68; #1;
      checks++; if (rdata1[30] !== 1'b1 || rdata1[15] !== 1'b1) begin errors++; $display("FAIL ti_set got=%b%b exp=11", rdata1[30], rdata1[15]); end
      checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL ti_irq got=%b exp=1", irq1); end
      checks++; if (rdata0 !== mrd(0, 8'h68) || irq0 !== mirq(0)) begin errors++; $display("FAIL ti_u0 got=%h/%b exp=%h/%b", rdata0, irq0, mrd(0, 8'h68), mirq(0)); end
      wr(8'h58, 32'h100);
      addr = 8'h68; #1;
      checks++; if (rdata1[30] !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("FAIL ti_clear got=%b/%b exp=0/0", rdata1[30], irq1); end
      checks++; if (rdata0[30] !== 1'b0 || irq0 !== 1'b0) begin errors++; $display("FAIL ti_clear_u0 got=%b/%b exp=0/0", rdata0[30], irq0); end
   endtask
   task automatic test_ext_int();
      wr(8'h60, 32'h00001001);
      ext_int = 6'b000100; #1;
      checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL ext_direct got=%b exp=1", irq1); end
      tick(); ext_int = 0; addr = 8'h68; #1;
      checks++; if (irq0 !== 1'b0 || rdata0[12] !== 1'b0) begin errors++; $display("FAIL ext_cyc1 got=%b/%b exp=0/0", irq0, rdata0[12]); end
      tick(); #1;
      checks++; if (irq0 !== 1'b1 || rdata0[12] !== 1'b1) begin errors++; $display("FAIL ext_cyc2 got=%b/%b exp=1/1", irq0, rdata0[12]); end
      tick(); #1;
      checks++; if (irq0 !== 1'b0 || rdata0[12] !== 1'b0) begin errors++; $display("FAIL ext_cyc3 got=%b/%b exp=0/0", irq0, rdata0[12]); end
   endtask
   task automatic test_exc();
      exc_valid = 1; exc_code = 5'd4; exc_bd = 1; exc_pc = 32'h80001004; exc_badvaddr = 32'h1233;
      tick();
      addr = 8'h68; #1;
      checks++; if (epc0 !== 32'h80001000) begin errors++; $display("FAIL exc_epc got=%h exp=80001000", epc0); end
      checks++; if (rdata0[31] !== 1'b1 || rdata0[6:2] !== 5'd4) begin errors++; $display("FAIL exc_cause got=%h exp=bd1 code4", rdata0); end
      addr = 8'h60; #1;
      checks++; if (rdata0[1] !== 1'b1) begin errors++; $display("FAIL exc_exl got=%b exp=1", rdata0[1]); end
      addr = 8'h40; #1;
      checks++; if (rdata0 !== 32'h1233 || rdata1 !== 32'h1233) begin errors++; $display("FAIL exc_bva got=%h/%h exp=1233", rdata0, rdata1); end
      exc_valid = 1; exc_code = 5'd0; exc_bd = 0; exc_pc = 32'h2000; exc_badvaddr = 32'h5555;
      tick();
      addr = 8'h40; #1;
      checks++; if (epc0 !== 32'h80001000 || epc1 !== 32'h80001000) begin errors++; $display("FAIL exc_nested_epc got=%h/%h exp=80001000", epc0, epc1); end
      checks++; if (rdata0 !== 32'h1233) begin errors++; $display("FAIL exc_bva_hold got=%h exp=1233", rdata0); end
      checks++; if (vec0 !== 32'hBFC00380) begin errors++; $display("FAIL exc_vec got=%h exp=bfc00380", vec0); end
      eret = 1; tick(); addr = 8'h60; #1;
      checks++; if (rdata0[1] !== 1'b0) begin errors++; $display("FAIL eret_exl got=%b exp=0", rdata0[1]); end
   endtask
   task automatic test_priority();
      exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h3000; eret = 1;
      wr(8'h60, 32'h0000FF01);
      addr = 8'h60; #1;
      checks++; if (rdata0 !== 32'h0040FF03) begin errors++; $display("FAIL prio_status got=%h exp=0040ff03", rdata0); end
      checks++; if (epc0 !== 32'h3000) begin errors++; $display("FAIL prio_epc got=%h exp=3000", epc0); end
      eret = 1; tick(); #1;
      checks++; if (rdata0[1] !== 1'b0) begin errors++; $display("FAIL prio_eret got=%b exp=0", rdata0[1]); end
   endtask
   task automatic test_random();
      logic [7:0] a [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h50};
      logic [4:0] cd [4] = '{5'd0, 5'd4, 5'd5, 5'd12};
      logic [7:0] ra;
      for (int n = 0; n < 300; n++) begin
         wr_en = ($urandom_range(0, 2) == 0);
         addr = a[$urandom_range(0, 5)];
         wdata = $urandom;
         if (addr == 8'h58 && $urandom_range(0, 1) == 1) wdata = mcount(1) + 32'($urandom_range(1, 6));
         if (addr == 8'h48 && $urandom_range(0, 1) == 1) wdata = cmp - 32'($urandom_range(1, 8));
         exc_valid = ($urandom_range(0, 9) == 0);
         exc_code = cd[$urandom_range(0, 3)];
         exc_bd = 1'($urandom);
         exc_pc = $urandom;
         exc_badvaddr = $urandom;
         eret = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) ext_int = 6'($urandom);
         tick();
         ra = a[$urandom_range(0, 6)];
         addr = ra; #1;
         checks++; if (rdata0 !== mrd(0, ra)) begin errors++; $display("FAIL rand_u0 n=%0d addr=%h got=%h exp=%h", n, ra, rdata0, mrd(0, ra)); end
         checks++; if (rdata1 !== mrd(1, ra)) begin errors++; $display("FAIL rand_u1 n=%0d addr=%h got=%h exp=%h", n, ra, rdata1, mrd(1, ra)); end
         checks++; if (irq0 !== mirq(0) || irq1 !== mirq(1)) begin errors++; $display("FAIL rand_irq n=%0d got=%b%b exp=%b%b", n, irq0, irq1, mirq(0), mirq(1)); end
         checks++; if (epc0 !== epc || epc1 !== epc) begin errors++; $display("FAIL rand_epc n=%0d got=%h/%h exp=%h", n, epc0, epc1, epc); end
      end
   endtask
   task automatic test_reset_mid();
      ext_int = 0;
      wr(8'h60, 32'h00008001);
      wr(8'h58, mcount(1) + 32'd2);
      repeat (3) tick();
      addr = 8'h68; #1;
      checks++; if (rdata1[30] !== 1'b1 || irq1 !== 1'b1) begin errors++; $display("FAIL mid_ti_pre got=%b/%b exp=1/1", rdata1[30], irq1); end
      rst = 0; exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h44; eret = 1;
      wr(8'h48, 32'h1234);
      addr = 8'h48; #1;
      checks++; if (rdata0 !== 0 || rdata1 !== 0) begin errors++; $display("FAIL mid_count got=%h/%h exp=0", rdata0, rdata1); end
      addr = 8'h68; #1;
      checks++; if (rdata0 !== 0 || rdata1 !== 0) begin errors++; $display("FAIL mid_cause got=%h/%h exp=0", rdata0, rdata1); end
      addr = 8'h58; #1;
      checks++; if (rdata1 !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_cmp got=%h exp=ffffffff", rdata1); end
      addr = 8'h60; #1;
      checks++; if (rdata1 !== 32'h00400000) begin errors++; $display("FAIL mid_status got=%h exp=00400000", rdata1); end
      addr = 8'h40; #1;
      checks++; if (rdata1 !== 0 || epc1 !== 0) begin errors++; $display("FAIL mid_bva_epc got=%h/%h exp=0/0", rdata1, epc1); end
      checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin errors++; $display("FAIL mid_irq got=%b%b exp=00", irq0, irq1); end
      rst = 1;
   endtask
   initial begin
      test_reset();
      test_count();
      test_timer();
      test_ext_int();
      test_exc();
      test_priority();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
